// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
// Purpose: FSM state encoding, instruction size and PC word-alignment mask.
// Ports: none (package).
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        KILL
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES   = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_hold_reg.sv
// rtl/fetch_hold_reg.sv - 32-bit buffer for an instruction that arrived while decode was busy
// Purpose: parks imem_rdata until the output slot frees up.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load         capture data_in on the next edge
//   clear        empty the buffer (wins over load)
//   data_in      instruction word from memory
//   data         buffered instruction word
module fetch_hold_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] data_in,
    output logic [31:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= 32'd0;
        end else if (clear) begin
            data <= 32'd0;
        end else if (load) begin
            data <= data_in;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage with redirect support
// Purpose: issues word fetches from the external PC register, delivers instructions
//          to decode through a one-entry output slot, and steers the PC register.
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   pc_in / pc_next / pc_stall      PC register value, its next value, hold control
//   redirect / redirect_target      taken branch or jump from a later stage
//   id_stall                        decode cannot accept the slot this cycle
//   imem_req / imem_addr            memory request and its word address
//   imem_ack / imem_rdata           memory completion and read data
//   instr_out / instr_pc / instr_valid  output slot to decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        pc_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    fetch_state_t state;
    logic         slot_free;
    logic [31:0]  addr_inc;
    logic [31:0]  hold_data;
    logic         hold_load;
    logic         hold_clear;

    // The slot can take a new instruction if it is empty or decode drains it this edge.
    assign slot_free = !instr_valid || !id_stall;
    assign addr_inc  = imem_addr + INSTR_BYTES;

    assign hold_load  = (state == WAIT) && imem_ack && !redirect && !slot_free;
    assign hold_clear = (state == HOLD) && (redirect || slot_free);

    fetch_hold_reg u_hold (
        .clk     (clk),
        .reset   (reset),
        .load    (hold_load),
        .clear   (hold_clear),
        .data_in (imem_rdata),
        .data    (hold_data)
    );

    // PC register steering: the PC only advances when an instruction enters the
    // slot, so pc_in always names the next word to fetch.
    always_comb begin
        pc_stall = 1'b1;
        pc_next  = pc_in;
        if (reset) begin
            pc_stall = 1'b0;
            pc_next  = RESET_PC;
        end else if (redirect) begin
            pc_stall = 1'b0;
            pc_next  = redirect_target & PC_ALIGN_MASK;
        end else begin
            case (state)
                IDLE: begin
                    pc_stall = 1'b0;
                    pc_next  = RESET_PC;
                end
                WAIT: begin
                    if (imem_ack && slot_free) begin
                        pc_stall = 1'b0;
                        pc_next  = addr_inc;
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        pc_stall = 1'b0;
                        pc_next  = addr_inc;
                    end
                end
                default: begin
                    pc_stall = 1'b1;
                    pc_next  = pc_in;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= 32'd0;
            instr_out   <= 32'd0;
            instr_pc    <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            // imem_req is raised only by branches that (re)enter WAIT or KILL.
            imem_req <= 1'b0;
            if (instr_valid && !id_stall) begin
                instr_valid <= 1'b0;
            end
            if (redirect) begin
                instr_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (!redirect && slot_free) begin
                        imem_addr <= pc_in;
                        imem_req  <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            state <= ISSUE;
                        end else if (slot_free) begin
                            instr_out   <= imem_rdata;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        // The request stays up until acked; a redirect only marks it stale.
                        imem_req <= 1'b1;
                        if (redirect) begin
                            state <= KILL;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        state <= ISSUE;
                    end else if (slot_free) begin
                        instr_out   <= hold_data;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                KILL: begin
                    if (imem_ack) begin
                        state <= ISSUE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        id_stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .pc_stall        (pc_stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_stall        (id_stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid)
    );

    int tests = 0;
    int fails = 0;

    // stimulus knobs
    int          lat_min = 0;
    int          lat_max = 0;
    int          stall_pct = 0;
    int          redir_pct = 0;
    int          force_stall = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_tgt = 32'd0;

    // memory model and reference state
    logic        outstanding = 1'b0;
    int          lat_left = 0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] last_pn = 32'd0;
    logic        last_ps = 1'b1;
    int          cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RPC) return 32'h8C01_0004;
        if (a == RPC + 32'd4) return 32'h0022_1820;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock: drive inputs at negedge, check, then advance past posedge.
    task automatic step();
        logic        ack;
        logic        rd;
        logic        v;
        logic        st;
        logic        ps;
        logic [31:0] tgt;
        logic [31:0] pn;
        logic [31:0] ip;
        logic [31:0] io;
        @(negedge clk);
        ack = 1'b0;
        if (imem_req) begin
            if (!outstanding) begin
                outstanding = 1'b1;
                lat_left    = $urandom_range(lat_max, lat_min);
                req_addr    = imem_addr;
            end else begin
                check("addr_stable", imem_addr, req_addr);
            end
            ack      = (lat_left == 0);
            lat_left = lat_left - 1;
        end else if (outstanding) begin
            check("req_held", 32'(imem_req), 32'd1);
        end
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom();
        if (ack) outstanding = 1'b0;
        id_stall = (force_stall >= 0) ? (force_stall != 0) : ($urandom_range(99) < stall_pct);
        rd  = force_redir || (int'($urandom_range(99)) < redir_pct);
        tgt = force_redir ? force_tgt : $urandom();
        force_redir     = 1'b0;
        redirect        = rd;
        redirect_target = tgt;
        #1;
        if (rd) begin
            check("redir_pc_next", pc_next, {tgt[31:2], 2'b00});
            check("redir_pc_stall", 32'(pc_stall), 32'd0);
        end
        v  = instr_valid;
        st = id_stall;
        ip = instr_pc;
        io = instr_out;
        ps = pc_stall;
        pn = pc_next;
        if (v && !st) begin
            check("instr_pc", ip, exp_pc);
            check("instr_out", io, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (rd) exp_pc = {tgt[31:2], 2'b00};
        @(posedge clk);
        #1;
        if (!ps) pc_in = pn;
        last_pn = pn;
        last_ps = ps;
        if (rd) begin
            check("valid_after_redirect", 32'(instr_valid), 32'd0);
        end else if (!ps && cycles > 0) begin
            check("advance_valid", 32'(instr_valid), 32'd1);
            check("advance_pc", pc_in, instr_pc + 32'd4);
        end
        cycles++;
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        outstanding = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pc_in = pc_next;
            check("rst_pc_next", pc_next, RPC);
            check("rst_pc_stall", 32'(pc_stall), 32'd0);
            check("rst_imem_req", 32'(imem_req), 32'd0);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_instr_pc", instr_pc, 32'd0);
            check("rst_imem_addr", imem_addr, 32'd0);
        end
        reset  = 1'b0;
        exp_pc = RPC;
        cycles = 0;
    endtask

    task automatic wait_new_req(input int max_steps);
        int n = 0;
        while (!(imem_req && !outstanding) && n < max_steps) begin
            step();
            n++;
        end
        check("new_req", 32'(imem_req && !outstanding), 32'd1);
    endtask

    initial begin
        // reset and first fetch address
        do_reset(3);
        wait_new_req(5);
        check("first_addr", imem_addr, RPC);

        // zero-wait memory, decode always ready: one instruction every 2 cycles
        step();
        check("z0_valid", 32'(instr_valid), 32'd1);
        check("z0_pc", instr_pc, RPC);
        check("z0_data", instr_out, 32'h8C01_0004);
        step();
        check("z1_gap", 32'(instr_valid), 32'd0);
        step();
        check("z2_valid", 32'(instr_valid), 32'd1);
        check("z2_pc", instr_pc, RPC + 32'd4);
        check("z2_data", instr_out, 32'h0022_1820);

        // decode stall holds the slot and blocks fetch
        force_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_valid", 32'(instr_valid), 32'd1);
            check("st_pc", instr_pc, RPC + 32'd4);
            check("st_req", 32'(imem_req), 32'd0);
            check("st_pc_stall", 32'(pc_stall), 32'd1);
        end
        force_stall = 0;
        step();
        step();
        check("st_next_valid", 32'(instr_valid), 32'd1);
        check("st_next_pc", instr_pc, RPC + 32'd8);

        // redirect in the 2nd cycle of a 3-cycle-latency fetch
        wait_new_req(5);
        lat_min = 3;
        lat_max = 3;
        step();
        force_redir = 1'b1;
        force_tgt   = 32'h0040_0100;
        step();
        check("kill_pn", last_pn, 32'h0040_0100);
        check("kill_ps", 32'(last_ps), 32'd0);
        check("kill_req", 32'(imem_req), 32'd1);
        check("kill_addr", imem_addr, RPC + 32'd12);
        lat_min = 0;
        lat_max = 0;
        wait_new_req(10);
        check("kill_next_addr", imem_addr, 32'h0040_0100);
        step();
        check("kill_deliver_pc", instr_pc, 32'h0040_0100);

        // redirect coinciding with ack, unaligned target
        wait_new_req(5);
        force_redir = 1'b1;
        force_tgt   = 32'h0040_0103;
        step();
        check("ack_redir_pn", last_pn, 32'h0040_0100);
        check("ack_redir_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) step();

        // address wrap at the top of memory
        force_redir = 1'b1;
        force_tgt   = 32'hFFFF_FFFC;
        step();
        for (int i = 0; i < 10 && !instr_valid; i++) step();
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc_next", pc_in, 32'h0000_0000);
        step();
        step();

        // randomized traffic with a mid-request reset
        lat_min     = 0;
        lat_max     = 3;
        stall_pct   = 30;
        redir_pct   = 5;
        force_stall = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                for (int k = 0; k < 20 && !imem_req; k++) step();
                reset = 1'b1;
                #1;
                check("midreq_reset_req", 32'(imem_req), 32'd0);
                do_reset(2);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, word-aligned address loaded into the PC register while in reset and in IDLE.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_in  input  32  current PC register value.
REQ-005 pc_next  output  32  next-PC value driven to the PC register data input.
REQ-006 pc_stall  output  1  PC register control: 0 loads pc_next, 1 holds.
REQ-007 redirect / redirect_target  input  1 / 32  taken branch or jump from a later stage, with its target.
REQ-008 id_stall  input  1  decode cannot accept; the output slot holds.
REQ-009 imem_req / imem_addr  output  1 / 32  instruction memory request and registered word address.
REQ-010 imem_ack / imem_rdata  input  1 / 32  memory completion and read data, valid in the ack cycle.
REQ-011 instr_out / instr_pc / instr_valid  output  32 / 32 / 1  fetched instruction, its address, and its qualifier.

Function
REQ-012 The slot is free when instr_valid==0 or id_stall==0.
REQ-013 The slot is consumed when instr_valid==1 and id_stall==0; instr_valid clears on that edge unless a new instruction loads it on the same edge.
REQ-014 Defaults in every state: pc_stall=1 and pc_next=pc_in.
REQ-015 Every redirect drives pc_next={redirect_target[31:2],2'b00} and pc_stall=0 in that cycle.
REQ-016 Every redirect clears instr_valid on the next edge; redirect has priority over all other events.
REQ-017 FSM states are IDLE, ISSUE, WAIT, HOLD and KILL.
REQ-018 IDLE: pc_stall=0 and pc_next=RESET_PC; the next state is ISSUE.
REQ-019 ISSUE with redirect: stay in ISSUE.
REQ-020 ISSUE with no redirect and the slot free: latch imem_addr<=pc_in and go to WAIT.
REQ-021 ISSUE with no redirect and the slot not free: stay in ISSUE.
REQ-022 imem_req==1 exactly in WAIT and KILL.
REQ-023 imem_addr is constant while imem_req==1, and imem_req never drops before imem_ack.
REQ-024 WAIT, ack with redirect: discard rdata and go to ISSUE.
REQ-025 WAIT, ack with the slot free: instr_out<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1; pc_next=imem_addr+4, pc_stall=0; go to ISSUE.
REQ-026 WAIT, ack with the slot not free: load rdata into the hold buffer and go to HOLD.
REQ-027 WAIT, redirect without ack: go to KILL.
REQ-028 HOLD with redirect: discard the buffer and go to ISSUE.
REQ-029 HOLD with the slot free: move the buffer to the outputs (instr_pc=imem_addr); pc_next=imem_addr+4, pc_stall=0; go to ISSUE.
REQ-030 HOLD with the slot not free: remain in HOLD with imem_req=0.
REQ-031 KILL: on ack, discard rdata and go to ISSUE; a further redirect in KILL applies REQ-015/REQ-016 and stays in KILL.
REQ-032 Minimum latency is 2 cycles per instruction (ISSUE plus a WAIT with same-cycle ack).
REQ-033 pc_next=imem_addr+4 is computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).

Reset
REQ-034 While reset==1: state=IDLE; instr_valid, instr_out, instr_pc, imem_addr and the hold buffer are 0; imem_req=0; pc_stall=0; pc_next=RESET_PC.
REQ-035 Reset asserted mid-request abandons the request immediately; the memory side tolerates the dropped request.

Structure
REQ-036 Package fetch_pkg holds the FSM state enum, INSTR_BYTES=4 and the PC alignment mask.
REQ-037 Sub-module fetch_hold_reg holds the 32-bit instruction buffer with load and clear; all other logic stays flat.

Verification
REQ-038 RESET_PC=0x00400000, reset high 3 cycles -> pc_next=0x00400000, pc_stall=0, imem_req=0, instr_valid=0; the first imem_addr after release is 0x00400000.
REQ-039 Zero-wait memory returning 0x8C010004 then 0x00221820, id_stall=0 -> instr_valid pulses every 2 cycles with instr_pc 0x00400000 then 0x00400004.
REQ-040 id_stall=1 with instr_valid=1 when ack arrives -> HOLD, pc_stall=1, imem_req=0; id_stall drops -> second instruction valid the next cycle and pc_next=imem_addr+4.
REQ-041 Ack delayed 3 cycles, redirect to 0x00400100 in the 2nd WAIT cycle -> that cycle pc_next=0x00400100 and pc_stall=0; stale rdata never appears; the next imem_addr is 0x00400100.
REQ-042 Redirect to 0x00400103 in the same cycle as ack -> rdata discarded, pc_next=0x00400100, instr_valid=0 the next cycle.
REQ-043 Fetch at pc_in=0xFFFFFFFC -> instr_pc=0xFFFFFFFC and pc_next=0x00000000.
